// File: rtl/clock_divider_bank.sv
// Multi-channel programmable square-wave / tick generator driven from one system clock.
// Latency: outputs are registered; an enabled channel first toggles at the H-th edge after it starts running.
// Backpressure: none; configuration writes are always accepted and take effect at the next half-period boundary.
//
// Ports:
//   clk_in    system clock, all logic on posedge
//   reset_n   synchronous active-low reset
//   cfg_we    half-period write strobe
//   cfg_ch    write target channel (values >= NUM_CH are ignored)
//   cfg_half  new half-period in clk_in cycles (0 is treated as 1)
//   ch_en     per-channel run enable
//   sync      hold all channels at phase zero while high
//   clk_out   registered square output per channel, period 2*half
//   tick      registered one-cycle pulse on each 0->1 of clk_out

module clock_divider_bank #(
   parameter int NUM_CH       = 4,
   parameter int DIV_W        = 26,
   parameter int DEFAULT_HALF = 25000000,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_half,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_HALF);
   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

   logic [DIV_W-1:0]  r_cnt       [NUM_CH];
   logic [DIV_W-1:0]  r_half_act  [NUM_CH];
   logic [DIV_W-1:0]  r_half_pend [NUM_CH];
   logic [NUM_CH-1:0] r_pend_v;
   logic [NUM_CH-1:0] r_out;
   logic [NUM_CH-1:0] r_tick;

   logic [NUM_CH-1:0] w_wr;
   logic [NUM_CH-1:0] w_wrap;
   logic [DIV_W-1:0]  w_half_new;

   // A half-period of zero would never terminate; clamp it to one cycle.
   assign w_half_new = (cfg_half == '0) ? ONE : cfg_half;

   // Channel decode: out-of-range channel numbers match no loop index and are dropped.
   always_comb begin
      w_wr = '0;
      if (cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
               w_wr[i] = 1'b1;
            end
         end
      end
   end

   // Half-period boundary. half_act only changes while cnt is 0, so cnt never
   // passes half_act-1 and an equality compare is sufficient.
   always_comb begin
      w_wrap = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_wrap[i] = (r_cnt[i] == (r_half_act[i] - ONE));
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!reset_n) begin
            r_cnt[i]       <= '0;
            r_out[i]       <= 1'b0;
            r_tick[i]      <= 1'b0;
            r_half_act[i]  <= DEF_HALF;
            r_half_pend[i] <= DEF_HALF;
            r_pend_v[i]    <= 1'b0;
         end else if (sync || !ch_en[i]) begin
            // Idle channel: no half-period in flight, so a new value can land
            // directly; a same-cycle write beats an older pending value.
            r_cnt[i]    <= '0;
            r_out[i]    <= 1'b0;
            r_tick[i]   <= 1'b0;
            r_pend_v[i] <= 1'b0;
            if (w_wr[i]) begin
               r_half_act[i] <= w_half_new;
            end else if (r_pend_v[i]) begin
               r_half_act[i] <= r_half_pend[i];
            end
         end else begin
            if (w_wrap[i]) begin
               r_cnt[i]  <= '0;
               r_out[i]  <= ~r_out[i];
               r_tick[i] <= ~r_out[i];
               if (r_pend_v[i]) begin
                  r_half_act[i] <= r_half_pend[i];
               end
            end else begin
               r_cnt[i]  <= r_cnt[i] + ONE;
               r_tick[i] <= 1'b0;
            end
            // A write landing on the boundary cycle is held for the next boundary.
            if (w_wr[i]) begin
               r_half_pend[i] <= w_half_new;
               r_pend_v[i]    <= 1'b1;
            end else if (w_wrap[i]) begin
               r_pend_v[i]    <= 1'b0;
            end
         end
      end
   end

   assign clk_out = r_out;
   assign tick    = r_tick;

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

   localparam int NUM_CH       = 3;
   localparam int DIV_W        = 8;
   localparam int DEFAULT_HALF = 3;
   localparam int CH_W         = 2;

   logic              clk_in;
   logic              reset_n;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_half;
   logic [NUM_CH-1:0] ch_en;
   logic              sync;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   int checks   = 0;
   int failures = 0;

   clock_divider_bank #(
      .NUM_CH       (NUM_CH),
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) dut (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_half (cfg_half),
      .ch_en    (ch_en),
      .sync     (sync),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ch_en   = 3'b111;
      step();
      step();
      checks++;
      if (clk_out !== 3'b000) begin
         failures++;
         $display("FAIL reset clk_out=%b expected=000", clk_out);
      end
      checks++;
      if (tick !== 3'b000) begin
         failures++;
         $display("FAIL reset tick=%b expected=000", tick);
      end
   endtask

   // H=3 on ch0/ch1: rise after edge 3, fall after 6, tick on 3, 9, 15.
   task automatic test_default();
      logic [2:0] eo, et;
      logic b;
      ch_en   = 3'b011;
      reset_n = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         step();
         b  = ((k / 3) % 2) == 1;
         eo = {1'b0, b, b};
         b  = (k % 6) == 3;
         et = {1'b0, b, b};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL default k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL default k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
   endtask

   // ch0 at H=3; write 9 then 5 while counting. Current half stays 3, then 5s.
   task automatic test_reconfig();
      logic [2:0] eo, et;
      logic b;
      ch_en = 3'b000;
      step();
      ch_en = 3'b001;
      for (int k = 1; k <= 18; k++) begin
         cfg_we   = (k == 1) || (k == 2);
         cfg_ch   = 2'd0;
         cfg_half = (k == 1) ? 8'd9 : 8'd5;
         step();
         b  = (k >= 3) && ((((k - 3) / 5) % 2) == 0);
         eo = {2'b00, b};
         et = {2'b00, (k == 3) || (k == 13)};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL reconfig k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL reconfig k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
      cfg_we = 1'b0;
   endtask

   // Zero half-period written to idle ch1 lands directly and behaves as H=1.
   task automatic test_zero_half();
      logic [2:0] eo;
      ch_en    = 3'b000;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd1;
      cfg_half = 8'd0;
      step();
      cfg_we = 1'b0;
      checks++;
      if (clk_out !== 3'b000) begin
         failures++;
         $display("FAIL zero_half_idle clk_out=%b expected=000", clk_out);
      end
      ch_en = 3'b010;
      for (int k = 1; k <= 8; k++) begin
         step();
         eo = {1'b0, (k % 2) == 1, 1'b0};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL zero_half k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== eo) begin
            failures++;
            $display("FAIL zero_half k=%0d tick=%b expected=%b", k, tick, eo);
         end
      end
   endtask

   // ch0 H=5, ch1 H=1 running; one sync cycle also writes H=4 to ch0 directly.
   task automatic test_sync();
      logic [2:0] eo, et;
      ch_en = 3'b011;
      for (int k = 0; k < 4; k++) step();
      sync     = 1'b1;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd0;
      cfg_half = 8'd4;
      step();
      sync   = 1'b0;
      cfg_we = 1'b0;
      checks++;
      if (clk_out !== 3'b000) begin
         failures++;
         $display("FAIL sync_hold clk_out=%b expected=000", clk_out);
      end
      checks++;
      if (tick !== 3'b000) begin
         failures++;
         $display("FAIL sync_hold tick=%b expected=000", tick);
      end
      for (int k = 1; k <= 12; k++) begin
         step();
         eo = {1'b0, (k % 2) == 1, ((k / 4) % 2) == 1};
         et = {1'b0, (k % 2) == 1, (k % 8) == 4};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL sync k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL sync k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
   endtask

   // cfg_ch=3 does not exist: writes while idle and while counting are ignored.
   task automatic test_invalid_ch();
      logic [2:0] eo, et;
      ch_en    = 3'b000;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd3;
      cfg_half = 8'd7;
      step();
      ch_en = 3'b011;
      for (int k = 1; k <= 12; k++) begin
         cfg_we = (k == 1);
         step();
         eo = {1'b0, (k % 2) == 1, ((k / 4) % 2) == 1};
         et = {1'b0, (k % 2) == 1, (k % 8) == 4};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL invalid_ch k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL invalid_ch k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
      cfg_we = 1'b0;
   endtask

   // ch0 H=4 high, pending H=2, then disabled: output drops, pending applied on re-enable.
   task automatic test_disable_pending();
      logic [2:0] eo, et;
      ch_en = 3'b000;
      step();
      ch_en = 3'b001;
      for (int k = 1; k <= 5; k++) begin
         cfg_we   = (k == 5);
         cfg_ch   = 2'd0;
         cfg_half = 8'd2;
         step();
         eo = {2'b00, ((k / 4) % 2) == 1};
         et = {2'b00, k == 4};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL dis_run k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL dis_run k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
      cfg_we = 1'b0;
      ch_en  = 3'b000;
      step();
      checks++;
      if (clk_out !== 3'b000) begin
         failures++;
         $display("FAIL dis_off clk_out=%b expected=000", clk_out);
      end
      ch_en = 3'b001;
      for (int k = 1; k <= 8; k++) begin
         step();
         eo = {2'b00, ((k / 2) % 2) == 1};
         et = {2'b00, (k % 4) == 2};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL dis_reen k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL dis_reen k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
   endtask

   // ch0 H=2 with a pending H=6; reset mid-period restores H=3 and drops the pending write.
   task automatic test_reset_mid();
      logic [2:0] eo, et;
      ch_en = 3'b000;
      step();
      ch_en = 3'b001;
      for (int k = 1; k <= 2; k++) begin
         cfg_we   = (k == 2);
         cfg_ch   = 2'd0;
         cfg_half = 8'd6;
         step();
         eo = {2'b00, k == 2};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL rstmid_run k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
      end
      cfg_we  = 1'b0;
      reset_n = 1'b0;
      step();
      checks++;
      if (clk_out !== 3'b000 || tick !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_hold clk_out=%b tick=%b expected=000/000", clk_out, tick);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         eo = {2'b00, ((k / 3) % 2) == 1};
         et = {2'b00, (k % 6) == 3};
         checks++;
         if (clk_out !== eo) begin
            failures++;
            $display("FAIL rstmid k=%0d clk_out=%b expected=%b", k, clk_out, eo);
         end
         checks++;
         if (tick !== et) begin
            failures++;
            $display("FAIL rstmid k=%0d tick=%b expected=%b", k, tick, et);
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_half = '0;
      ch_en    = '0;
      sync     = 1'b0;
      test_reset();
      test_default();
      test_reconfig();
      test_zero_half();
      test_sync();
      test_invalid_ch();
      test_disable_pending();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
